// File: rtl/fir_channel_arbiter.sv
// Round-robin arbiter time-sharing one FIR filter unit between NCH channels.
// Optional WAIT-state watchdog enabled by defining FIR_ARB_WATCHDOG_EN.
module fir_channel_arbiter #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned DW      = 16,
    parameter int unsigned RW      = 36,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned CHB    = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req_in,
    input  logic [NCH*DW-1:0] sample_in,
    output logic [NCH-1:0]    ack_out,
    output logic              filt_start_out,
    output logic [DW-1:0]     filt_data_out,
    output logic [CHB-1:0]    filt_ch_out,
    input  logic              filt_done_in,
    input  logic [RW-1:0]     filt_result_in,
    output logic              result_valid_out,
    output logic [RW-1:0]     result_out,
    output logic [CHB-1:0]    result_ch_out,
    input  logic              result_ready_in,
    output logic              err_out
);

    if (NCH < 2 || NCH > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("fir_channel_arbiter: NCH must be 2..16 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_OUT} state_t;

    state_t         state;
    logic [CHB-1:0] last_r;
    logic [CHB-1:0] win;
    logic [CHB-1:0] idx;
    logic           found;

`ifdef FIR_ARB_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;
`endif

    // First requester strictly after last_r, searching upward modulo NCH.
    always_comb begin
        win   = last_r;
        idx   = last_r;
        found = 1'b0;
        for (int unsigned i = 1; i <= NCH; i++) begin
            idx = CHB'((32'(last_r) + i) % NCH);
            if (!found && req_in[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            last_r           <= CHB'(NCH - 1);
            ack_out          <= '0;
            filt_start_out   <= 1'b0;
            filt_data_out    <= '0;
            filt_ch_out      <= '0;
            result_valid_out <= 1'b0;
            result_out       <= '0;
            result_ch_out    <= '0;
            err_out          <= 1'b0;
`ifdef FIR_ARB_WATCHDOG_EN
            wd_cnt           <= '0;
`endif
        end else begin
            ack_out        <= '0;
            filt_start_out <= 1'b0;
            err_out        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        filt_data_out  <= sample_in[32'(win)*DW +: DW];
                        filt_ch_out    <= win;
                        last_r         <= win;
                        ack_out        <= NCH'(1) << win;
                        filt_start_out <= 1'b1;
                        state          <= S_START;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
`ifdef FIR_ARB_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (filt_done_in) begin
                        result_out       <= filt_result_in;
                        result_ch_out    <= filt_ch_out;
                        result_valid_out <= 1'b1;
                        state            <= S_OUT;
                    end
`ifdef FIR_ARB_WATCHDOG_EN
                    else if (wd_cnt == WDW'(TIMEOUT - 1)) begin
                        // Abort: last_r keeps the stuck channel so arbitration moves on.
                        err_out <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
`endif
                end
                S_OUT: begin
                    if (result_ready_in) begin
                        result_valid_out <= 1'b0;
                        state            <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
